// File: rtl/hyperram_pkg.sv
// Shared types and constants for the auto-direction HyperRAM bridge.
// The CA bit offsets count down from the MSB of the first CA transfer.
package hyperram_pkg;

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, ERR} state_t;

  localparam int CA_RW_BIT  = 1;
  localparam int CA_REG_BIT = 2;

  function automatic int ca_cycles(input int dq_width);
    return 48 / dq_width;
  endfunction

endpackage

// File: rtl/hyperram_dir_ctrl.sv
// Registered tristate enables for the DQ/RWDS buffers, derived from the next FSM state
// so each direction change lands on the same edge as the state change.
module hyperram_dir_ctrl
  import hyperram_pkg::*;
(
  input  logic   ck,
  input  logic   reset,
  input  state_t state_nxt,
  input  logic   rw,
  input  logic   reg_wr,
  output logic   dq_h2r,
  output logic   dq_r2h,
  output logic   rwds_h2r,
  output logic   rwds_r2h
);

  logic dh, dr, rh, rr;

  always_comb begin
    dh = 1'b0;
    dr = 1'b0;
    rh = 1'b0;
    rr = 1'b0;
    case (state_nxt)
      CA: begin
        dh = 1'b1;
        rr = 1'b1;
      end
      LAT, WDATA, RDATA: begin
        if (rw) begin
          dr = 1'b1;
          rr = 1'b1;
        end else begin
          dh = 1'b1;
          rh = !reg_wr;
        end
      end
      default: ;
    endcase
  end

  // RAM->host loses to host->RAM so the pair can never both be on.
  always_ff @(posedge ck) begin
    if (reset) begin
      dq_h2r   <= 1'b0;
      dq_r2h   <= 1'b0;
      rwds_h2r <= 1'b0;
      rwds_r2h <= 1'b0;
    end else begin
      dq_h2r   <= dh;
      dq_r2h   <= dr & ~dh;
      rwds_h2r <= rh;
      rwds_r2h <= rr & ~rh;
    end
  end

endmodule

// File: rtl/hyperram_auto_bridge.sv
// HyperRAM bridge that decodes the CA phase itself to steer DQ/RWDS direction,
// generates the RAM clock, arbitrates chip selects and counts transactions.
module hyperram_auto_bridge
  import hyperram_pkg::*;
#(
  parameter int DQ_WIDTH      = 8,
  parameter int CHANNELS      = 1,
  parameter int LATENCY       = 6,
  parameter int FIXED_LATENCY = 1
) (
  input  logic                ck,
  input  logic                reset,
  input  logic                nreset,
  input  logic [CHANNELS-1:0] ncs,
  inout  wire                 rwds,
  inout  wire  [DQ_WIDTH-1:0] dq,
  output logic                hyperram_ck,
  output logic                hyperram_ckn,
  output logic                hyperram_nreset,
  output logic [CHANNELS-1:0] hyperram_ncs,
  inout  wire                 hyperram_rwds,
  inout  wire  [DQ_WIDTH-1:0] hyperram_dq,
  output logic [CHANNELS-1:0] leds,
  output logic                error,
  output logic [15:0]         txn_count
);

  localparam int CA_CYC = ca_cycles(DQ_WIDTH);
  localparam int CHW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t              state, state_nxt;
  logic [CHW-1:0]      ch, ch_nxt, low_idx;
  logic [5:0]          cnt, lat_load;
  logic [2:0]          n_low;
  logic                act_ncs, others_low, busy_nxt;
  logic                rw, is_reg, dbl, reg_wr;
  logic [CHANNELS-1:0] leds_nxt;
  logic                dq_h2r, dq_r2h, rwds_h2r, rwds_r2h;

  assign reg_wr   = !rw && is_reg;
  assign lat_load = dbl ? 6'(4*LATENCY - CA_CYC) : 6'(2*LATENCY - CA_CYC);

  always_comb begin
    n_low   = '0;
    low_idx = '0;
    act_ncs = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!ncs[i]) begin
        n_low   = n_low + 3'd1;
        low_idx = CHW'(i);
      end
      if (CHW'(i) == ch) act_ncs = ncs[i];
    end
  end

  assign others_low = act_ncs ? (n_low != 3'd0) : (n_low > 3'd1);

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    case (state)
      IDLE: begin
        if (n_low == 3'd1) begin
          state_nxt = CA;
          ch_nxt    = low_idx;
        end else if (n_low > 3'd1) begin
          state_nxt = ERR;
        end
      end
      ERR: if (n_low == 3'd0) state_nxt = IDLE;
      default: begin
        if (others_low)   state_nxt = ERR;
        else if (act_ncs) state_nxt = IDLE;
        else if (state == CA && cnt == 6'(CA_CYC - 1))
          // Register writes, or a latency fully hidden by the CA phase, skip LAT.
          state_nxt = (reg_wr || lat_load == 6'd0) ? (rw ? RDATA : WDATA) : LAT;
        else if (state == LAT && cnt == 6'd1)
          state_nxt = rw ? RDATA : WDATA;
      end
    endcase
  end

  assign busy_nxt = !(state_nxt == IDLE || state_nxt == ERR);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      leds_nxt[i] = !(busy_nxt && CHW'(i) == ch_nxt);
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state        <= IDLE;
      ch           <= '0;
      cnt          <= '0;
      rw           <= 1'b0;
      is_reg       <= 1'b0;
      dbl          <= 1'b0;
      hyperram_ck  <= 1'b0;
      hyperram_ncs <= '1;
      leds         <= '1;
      error        <= 1'b0;
      txn_count    <= '0;
    end else begin
      state        <= state_nxt;
      ch           <= ch_nxt;
      hyperram_ncs <= (state_nxt == ERR) ? '1 : ncs;
      hyperram_ck  <= busy_nxt ? ~hyperram_ck : 1'b0;
      leds         <= leds_nxt;
      if (state_nxt == ERR) error <= 1'b1;
      if ((state == WDATA || state == RDATA) && state_nxt == IDLE)
        txn_count <= txn_count + 16'd1;
      if (state == CA && cnt == 6'd0) begin
        rw     <= dq[DQ_WIDTH-CA_RW_BIT];
        is_reg <= dq[DQ_WIDTH-CA_REG_BIT];
        dbl    <= (FIXED_LATENCY != 0) || hyperram_rwds;
      end
      case (state)
        CA:      cnt <= (state_nxt == LAT) ? lat_load : cnt + 6'd1;
        LAT:     cnt <= cnt - 6'd1;
        default: cnt <= '0;
      endcase
    end
  end

  hyperram_dir_ctrl u_dir (
    .ck       (ck),
    .reset    (reset),
    .state_nxt(state_nxt),
    .rw       (state_nxt == CA ? 1'b0 : rw),
    .reg_wr   (reg_wr),
    .dq_h2r   (dq_h2r),
    .dq_r2h   (dq_r2h),
    .rwds_h2r (rwds_h2r),
    .rwds_r2h (rwds_r2h)
  );

  assign hyperram_ckn    = ~hyperram_ck;
  assign hyperram_nreset = nreset & ~reset;

  assign hyperram_dq   = dq_h2r   ? dq            : 'z;
  assign dq            = dq_r2h   ? hyperram_dq   : 'z;
  assign hyperram_rwds = rwds_h2r ? rwds          : 1'bz;
  assign rwds          = rwds_r2h ? hyperram_rwds : 1'bz;

endmodule

// File: tb/tb_hyperram_auto_bridge.sv
// Bench for hyperram_auto_bridge: an 8-bit two-channel variable-latency instance and a
// 16-bit fixed-latency instance, with host/RAM bus models and a data scoreboard.
module tb_hyperram_auto_bridge;
  import hyperram_pkg::*;

  logic ck = 1'b0;
  logic reset, nreset;
  always #5 ck = ~ck;

  // 8-bit, 2 channels, variable latency
  logic [1:0]  ncs;
  logic [7:0]  h_dq, r_dq;
  logic        h_dq_oe, r_dq_oe, h_rwds, h_rwds_oe, r_rwds, r_rwds_oe;
  wire  [7:0]  dq, hdq;
  wire         rwds, hrwds;
  logic        hck, hckn, hnrst, err;
  logic [1:0]  hncs, leds;
  logic [15:0] txn;

  assign dq    = h_dq_oe   ? h_dq   : 'z;
  assign hdq   = r_dq_oe   ? r_dq   : 'z;
  assign rwds  = h_rwds_oe ? h_rwds : 1'bz;
  assign hrwds = r_rwds_oe ? r_rwds : 1'bz;

  hyperram_auto_bridge #(.DQ_WIDTH(8), .CHANNELS(2), .LATENCY(6), .FIXED_LATENCY(0)) dut8 (
    .ck(ck), .reset(reset), .nreset(nreset), .ncs(ncs), .rwds(rwds), .dq(dq),
    .hyperram_ck(hck), .hyperram_ckn(hckn), .hyperram_nreset(hnrst), .hyperram_ncs(hncs),
    .hyperram_rwds(hrwds), .hyperram_dq(hdq), .leds(leds), .error(err), .txn_count(txn)
  );

  // 16-bit, 1 channel, fixed latency
  logic        w_ncs;
  logic [15:0] w_hd, w_rd;
  logic        w_hd_oe, w_rd_oe, w_rr, w_rr_oe;
  wire  [15:0] w_dq, w_hdq;
  wire         w_rwds, w_hrwds;
  logic        w_hck, w_hckn, w_hnrst, w_err, w_leds, w_hncs;
  logic [15:0] w_txn;

  assign w_dq    = w_hd_oe ? w_hd : 'z;
  assign w_hdq   = w_rd_oe ? w_rd : 'z;
  assign w_hrwds = w_rr_oe ? w_rr : 1'bz;

  hyperram_auto_bridge #(.DQ_WIDTH(16), .CHANNELS(1), .LATENCY(6), .FIXED_LATENCY(1)) dut16 (
    .ck(ck), .reset(reset), .nreset(nreset), .ncs(w_ncs), .rwds(w_rwds), .dq(w_dq),
    .hyperram_ck(w_hck), .hyperram_ckn(w_hckn), .hyperram_nreset(w_hnrst), .hyperram_ncs(w_hncs),
    .hyperram_rwds(w_hrwds), .hyperram_dq(w_hdq), .leds(w_leds), .error(w_err), .txn_count(w_txn)
  );

  int          total = 0, bad = 0;
  logic [15:0] sb[$];
  logic [15:0] model_txn = 16'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic txn8(input logic [1:0] sel, input logic [7:0] ca0, input logic lat_rwds,
                      input int exp_lat, input int nbytes);
    logic rd, regw, ckx;
    int   n;
    rd   = ca0[7];
    regw = !ca0[7] && ca0[6];
    ncs  = sel;
    step();
    chk("ca_leds", leds, sel);
    chk("ca_hncs", hncs, sel);
    ckx = 1'b1;
    for (int i = 0; i < 6; i++) begin
      h_dq = (i == 0) ? ca0 : 8'(17 * i);
      h_dq_oe = 1'b1; r_rwds = lat_rwds; r_rwds_oe = 1'b1;
      #1;
      chk("ca_dq", hdq, h_dq);
      chk("ca_rwds", rwds, lat_rwds);
      chk("ca_ck", hck, ckx);
      ckx = ~ckx;
      step();
    end
    h_dq_oe = 1'b0;
    if (!rd) r_rwds_oe = 1'b0;
    n = 0;
    while (dut8.state == LAT && n < 100) begin
      n++;
      step();
    end
    chk("lat_cyc", n, exp_lat);
    chk("data_state", dut8.state, rd ? RDATA : WDATA);
    for (int i = 0; i < nbytes; i++) begin
      if (rd) begin
        r_dq = 8'hC0 + 8'(i); r_dq_oe = 1'b1; r_rwds = i[0];
        sb.push_back(16'(r_dq));
        #1;
        chk("rd_dq", dq, sb.pop_front());
        chk("rd_rwds", rwds, r_rwds);
      end else begin
        h_dq = (i == 0) ? 8'h55 : 8'hA0 + 8'(i); h_dq_oe = 1'b1;
        sb.push_back(16'(h_dq));
        if (regw && i[0]) begin r_rwds = 1'b1; r_rwds_oe = 1'b1; end
        else begin h_rwds = 1'b1; h_rwds_oe = 1'b1; end
        #1;
        chk("wr_dq", hdq, sb.pop_front());
        if (!regw)     chk("wr_rwds", hrwds, 1);
        else if (i[0]) chk("reg_rwds_r2h", rwds === 1'b1, 0);
        else           chk("reg_rwds_h2r", hrwds === 1'b1, 0);
        h_rwds_oe = 1'b0; r_rwds_oe = 1'b0;
      end
      step();
    end
    h_dq_oe = 1'b0; r_dq_oe = 1'b0; r_rwds_oe = 1'b0; h_rwds_oe = 1'b0;
    ncs = 2'b11;
    step();
    model_txn++;
    chk("end_txn", txn, model_txn);
    chk("end_leds", leds, 2'b11);
    chk("end_ck", hck, 0);
    chk("end_hncs", hncs, 2'b11);
    r_dq = 8'h3C; r_dq_oe = 1'b1;
    #1;
    chk("idle_dq_off", dq === 8'h3C, 0);
    r_dq_oe = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ckx;
    int   n;
    reset = 1'b1; nreset = 1'b1; ncs = 2'b11; w_ncs = 1'b1;
    h_dq = '0; r_dq = '0; h_rwds = 1'b0; r_rwds = 1'b0;
    h_dq_oe = 1'b0; r_dq_oe = 1'b0; h_rwds_oe = 1'b0; r_rwds_oe = 1'b0;
    w_hd = '0; w_rd = '0; w_rr = 1'b0; w_hd_oe = 1'b0; w_rd_oe = 1'b0; w_rr_oe = 1'b0;
    #1;
    chk("rst_nreset", hnrst, 0);
    step(); step();
    chk("rst_hncs", hncs, 2'b11);
    chk("rst_leds", leds, 2'b11);
    chk("rst_ck", hck, 0);
    chk("rst_ckn", hckn, 1);
    chk("rst_err", err, 0);
    chk("rst_txn", txn, 0);
    reset = 1'b0;
    #1;
    chk("nreset_rel", hnrst, 1);
    step();

    txn8(2'b10, 8'hA0, 1'b1, 18, 4);  // memory read, RWDS high -> double latency
    txn8(2'b10, 8'h20, 1'b0, 6, 3);   // memory write, RWDS low -> single latency
    txn8(2'b10, 8'h60, 1'b0, 0, 2);   // register write, no latency
    txn8(2'b01, 8'hA0, 1'b0, 6, 2);   // read on channel 1, single latency

    // ncs rising during CA aborts without counting
    ncs = 2'b10; step(); step();
    ncs = 2'b11; step();
    chk("abort_txn", txn, model_txn);
    chk("abort_leds", leds, 2'b11);
    step();

    // simultaneous chip selects from IDLE
    chk("err_pre", err, 0);
    ncs = 2'b00; step();
    chk("err_set", err, 1);
    chk("err_hncs", hncs, 2'b11);
    chk("err_leds", leds, 2'b11);
    chk("err_ck", hck, 0);
    h_dq = 8'hA5; h_dq_oe = 1'b1;
    #1;
    chk("err_dq_h2r_off", hdq === 8'hA5, 0);
    h_dq_oe = 1'b0; r_dq = 8'h5A; r_dq_oe = 1'b1;
    #1;
    chk("err_dq_r2h_off", dq === 8'h5A, 0);
    r_dq_oe = 1'b0;
    ncs = 2'b11; step();
    chk("err_sticky", err, 1);
    chk("err_to_idle", dut8.state, IDLE);

    // second chip select falling mid-transaction
    ncs = 2'b10; step();
    ncs = 2'b00; step();
    chk("mid_err_state", dut8.state, ERR);
    chk("mid_err_hncs", hncs, 2'b11);
    ncs = 2'b11; step(); step();
    chk("mid_err_txn", txn, model_txn);

    // 16-bit fixed-latency read: RWDS low during CA must still give double latency
    w_ncs = 1'b0; step();
    ckx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_hd = (i == 0) ? 16'h8000 : 16'(i); w_hd_oe = 1'b1; w_rr = 1'b0; w_rr_oe = 1'b1;
      #1;
      chk("w_ca_dq", w_hdq, w_hd);
      chk("w_ca_ck", w_hck, ckx);
      ckx = ~ckx;
      step();
    end
    w_hd_oe = 1'b0;
    n = 0;
    while (dut16.state == LAT && n < 100) begin
      chk("w_lat_ck", w_hck, ckx);
      ckx = ~ckx;
      n++;
      step();
    end
    chk("w_lat", n, 21);
    chk("w_state", dut16.state, RDATA);
    for (int i = 0; i < 2; i++) begin
      w_rd = 16'hBEE0 + 16'(i); w_rd_oe = 1'b1;
      sb.push_back(w_rd);
      #1;
      chk("w_rd_dq", w_dq, sb.pop_front());
      chk("w_rd_ck", w_hck, ckx);
      ckx = ~ckx;
      step();
    end
    w_rd_oe = 1'b0; w_rr_oe = 1'b0; w_ncs = 1'b1;
    step();
    chk("w_end_ck", w_hck, 0);
    chk("w_end_ckn", w_hckn, 1);
    chk("w_txn", w_txn, 1);

    // reset in the middle of a read
    ncs = 2'b10; step();
    h_dq = 8'hA0; h_dq_oe = 1'b1; r_rwds = 1'b1; r_rwds_oe = 1'b1;
    repeat (6) step();
    h_dq_oe = 1'b0;
    repeat (3) step();
    chk("pre_rst_state", dut8.state, LAT);
    reset = 1'b1; ncs = 2'b11; r_rwds_oe = 1'b0;
    #1;
    chk("mid_rst_nreset", hnrst, 0);
    step();
    chk("mrst_hncs", hncs, 2'b11);
    chk("mrst_leds", leds, 2'b11);
    chk("mrst_txn", txn, 0);
    chk("mrst_err", err, 0);
    chk("mrst_ck", hck, 0);
    chk("mrst_w_txn", w_txn, 0);
    r_dq = 8'h69; r_dq_oe = 1'b1;
    #1;
    chk("mrst_dq_off", dq === 8'h69, 0);
    r_dq_oe = 1'b0; r_rwds = 1'b1; r_rwds_oe = 1'b1;
    #1;
    chk("mrst_rwds_off", rwds === 1'b1, 0);
    r_rwds_oe = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("post_rst_nreset", hnrst, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
